// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and the instruction memory (slave).
interface fetch_unit_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_rdata;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_stall,
        input  imem_done,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_stall,
        output imem_done,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage of the WISC pipeline: owns the PC, issues instruction reads to a possibly multi-cycle
// memory and fills the IF/ID register, handling hazard stalls, redirect squash and HALT.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INST    = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          branch,
    input  logic [15:0]   pcbranch,
    input  logic          stall,
    fetch_unit_if.master  imem,
    output logic [15:0]   InstOut,
    output logic [15:0]   pcplus2Out,
    output logic          valid,
    output logic          halted,
    output logic          err
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DROP  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] skid;

    logic [15:0] pc_inc;
    logic        deliver;
    logic [15:0] deliver_inst;
    logic        is_halt;

    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

    assign imem.imem_rd   = (state == FETCH);
    assign imem.imem_addr = pc;

    assign pc_inc       = pc + 16'd2;
    assign deliver      = !stall && ((state == WAIT && imem.imem_done) || state == HOLD);
    assign deliver_inst = (state == HOLD) ? skid : imem.imem_rdata;
    assign is_halt      = (deliver_inst[15:11] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            InstOut    <= NOP_INST;
            pcplus2Out <= 16'h0000;
            valid      <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
        end else begin
            // A response with no read outstanding is a protocol error.
            if (imem.imem_done && (state == FETCH || state == HALT))
                err <= 1'b1;

            if (branch) begin
                pc      <= align_pc(pcbranch);
                InstOut <= NOP_INST;
                valid   <= 1'b0;
                halted  <= 1'b0;
                if (pcbranch[0])
                    err <= 1'b1;
                // A read still in flight must be drained before fetching from the new target.
                case (state)
                    FETCH:   state <= imem.imem_stall ? FETCH : DROP;
                    WAIT:    state <= imem.imem_done ? FETCH : DROP;
                    DROP:    state <= imem.imem_done ? FETCH : DROP;
                    default: state <= FETCH;
                endcase
            end else begin
                if (deliver) begin
                    InstOut    <= deliver_inst;
                    pcplus2Out <= pc_inc;
                    valid      <= 1'b1;
                    pc         <= pc_inc;
                    if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= FETCH;
                    end
                end else if (!stall) begin
                    InstOut <= NOP_INST;
                    valid   <= 1'b0;
                end

                case (state)
                    FETCH: begin
                        if (!imem.imem_stall)
                            state <= WAIT;
                    end
                    WAIT: begin
                        if (imem.imem_done && stall) begin
                            skid  <= imem.imem_rdata;
                            state <= HOLD;
                        end
                    end
                    DROP: begin
                        if (imem.imem_done)
                            state <= FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
